// File: rtl/binary_maxpool.sv
// ---------------------------------------------------------------------------
// binary_maxpool
//
// Walks a list of square binary matrices stored in a conv-output SRAM and
// writes their 2x2 OR-pooled versions, packed back to back, into a
// pooled-output SRAM. Each input matrix is a header word (N in bits[4:0])
// followed by N row words; each output matrix is a header word (M = N/2)
// followed by M pooled rows. A header with N outside 2..16 ends the list,
// and a single 0x0000 word is written after the last pooled matrix.
//
// Ports
//   clk                      single clock, rising edge
//   reset_b                  asynchronous active-low reset
//   pool_run                 start request, only looked at while idle
//   pool_busy                high while a job is running
//   pool_sram_read_address   conv-output SRAM address (data returns 1 cycle later)
//   sram_pool_read_data      conv-output SRAM read data
//   pool_sram_write_address  pooled-output SRAM address
//   pool_sram_write_data     pooled-output SRAM write data
//   pool_sram_write_enable   one-cycle strobe per written word
// ---------------------------------------------------------------------------
module binary_maxpool #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              pool_run,
    output logic              pool_busy,
    output logic [ADDR_W-1:0] pool_sram_read_address,
    input  logic [DATA_W-1:0] sram_pool_read_data,
    output logic [ADDR_W-1:0] pool_sram_write_address,
    output logic [DATA_W-1:0] pool_sram_write_data,
    output logic              pool_sram_write_enable
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] ROW_A = 3'd2;
    localparam logic [2:0] ROW_B = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] TERM  = 3'd5;

    // A row can never be wider than the SRAM word.
    localparam int N_MAX = (DATA_W < 16) ? DATA_W : 16;

    logic [2:0]        state;
    logic [4:0]        hdr_n;
    logic              hdr_valid;
    logic [3:0]        m_size;
    logic [3:0]        pair_idx;
    logic              last_pair;
    logic [ADDR_W-1:0] next_hdr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              b_valid;
    logic              pend;
    logic [DATA_W-1:0] row_a;
    logic [DATA_W-1:0] row_or;
    logic [DATA_W-1:0] pooled;

    assign hdr_n     = sram_pool_read_data[4:0];
    assign hdr_valid = (hdr_n >= 5'd2) && (int'(hdr_n) <= N_MAX);
    assign last_pair = (pair_idx == (m_size - 4'd1));

    // Horizontal half of the 2x2 OR: the vertical half is already folded
    // into row_or. Columns at or beyond 2M (including the dropped last
    // column of an odd N and everything above N) never reach the output.
    always_comb begin
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (j < int'(m_size)) begin
                pooled[j] = row_or[2*j] | row_or[2*j+1];
            end
        end
    end

    // Row datapath. The even row arrives while in ROW_B, the odd row one
    // cycle later (b_valid); their vertical OR is held for one cycle so the
    // write lands two cycles after the odd row's data.
    always_ff @(posedge clk) begin
        if (state == ROW_B) begin
            row_a <= sram_pool_read_data;
        end
        if (b_valid) begin
            row_or <= row_a | sram_pool_read_data;
        end
    end

    // Control FSM plus registered SRAM ports. Read addresses are issued
    // every cycle through a matrix; the loop runs ROW_A/ROW_B directly while
    // pairs remain so a pooled row comes out every two cycles, and WRITE
    // is only used to drain the final row before the next header is taken
    // (otherwise the last row's strobe would collide with the next header's).
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                   <= IDLE;
            pool_busy               <= 1'b0;
            pool_sram_write_enable  <= 1'b0;
            pool_sram_read_address  <= '0;
            pool_sram_write_address <= '0;
            pool_sram_write_data    <= '0;
            wr_ptr                  <= '0;
            next_hdr                <= '0;
            m_size                  <= '0;
            pair_idx                <= '0;
            b_valid                 <= 1'b0;
            pend                    <= 1'b0;
        end else begin
            b_valid                <= (state == ROW_B);
            pend                   <= b_valid;
            pool_sram_write_enable <= 1'b0;

            if (pend) begin
                pool_sram_write_enable  <= 1'b1;
                pool_sram_write_address <= wr_ptr;
                pool_sram_write_data    <= pooled;
                wr_ptr                  <= wr_ptr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    // The read address already sits at 0 here, so the first
                    // header is valid on the very first HDR cycle.
                    if (pool_run) begin
                        state     <= HDR;
                        pool_busy <= 1'b1;
                        wr_ptr    <= '0;
                    end
                end
                HDR: begin
                    if (hdr_valid) begin
                        state                   <= ROW_A;
                        pool_sram_write_enable  <= 1'b1;
                        pool_sram_write_address <= wr_ptr;
                        pool_sram_write_data    <= DATA_W'(hdr_n[4:1]);
                        wr_ptr                  <= wr_ptr + ADDR_W'(1);
                        m_size                  <= hdr_n[4:1];
                        pair_idx                <= '0;
                        pool_sram_read_address  <= pool_sram_read_address + ADDR_W'(1);
                        next_hdr                <= pool_sram_read_address + ADDR_W'(hdr_n) + ADDR_W'(1);
                    end else begin
                        state                   <= TERM;
                        pool_busy               <= 1'b0;
                        pool_sram_write_enable  <= 1'b1;
                        pool_sram_write_address <= wr_ptr;
                        pool_sram_write_data    <= '0;
                    end
                end
                ROW_A: begin
                    state                  <= ROW_B;
                    pool_sram_read_address <= pool_sram_read_address + ADDR_W'(1);
                end
                ROW_B: begin
                    pair_idx <= pair_idx + 4'd1;
                    if (last_pair) begin
                        // Jump over a dropped odd row straight to the next header.
                        state                  <= WRITE;
                        pool_sram_read_address <= next_hdr;
                    end else begin
                        state                  <= ROW_A;
                        pool_sram_read_address <= pool_sram_read_address + ADDR_W'(1);
                    end
                end
                WRITE: begin
                    if (pend) begin
                        state <= HDR;
                    end
                end
                TERM: begin
                    state                  <= IDLE;
                    pool_sram_read_address <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
